nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that adds two NIBBLES*4-bit operands one nibble per cycle through a single 4-bit ripple adder, with a registered inter-nibble carry.
- Sits directly downstream of the operand source and wraps the team's 4-bit full-adder stage, reusing it sequentially instead of replicating it.
- Start/busy/done handshake; the result is held until the next accepted start.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand/result width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when the block accepts (IDLE or DONE state).
- a  input  W  operand A; latched on accepted start.
- b  input  W  operand B; latched on accepted start.
- ci  input  1  carry-in to nibble 0; latched on accepted start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; s/co valid.
- s  output  W  sum; held from done until the next accepted start.
- co  output  1  carry out of the top nibble; held with s.
- ovf  output  1  signed overflow; present only with SER_ADD_OVF_EN.

Behaviour:
- Reset is synchronous and active-high on clk. On rst:
  - state=IDLE.
  - busy=0, done=0, s=0, co=0, ovf=0.
  - Nibble counter and carry register cleared.
  - Reset during RUN aborts the operation, with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b, ci into shift registers, sets cnt=0, goes to RUN.
  - RUN: each edge adds nibble cnt (A[cnt], B[cnt], carry_reg) via the sub-module.
    - Writes the 4-bit sum into result nibble cnt and updates carry_reg with the nibble carry-out.
    - Increments cnt.
    - When the edge processes cnt=NIBBLES-1, goes to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted: latch new operands, go to RUN (back-to-back).
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0 → done high after edge E0+NIBBLES, i.e. NIBBLES+1 cycles from the start sample. Throughput is one result per NIBBLES+1 cycles.
- start while busy=1 is ignored; the latched operands are unaffected.
- a, b, ci may change freely after acceptance.
- s and co are updated only on the final RUN edge, not nibble-by-nibble. An internal result register feeds s.
- Arithmetic is unsigned modulo 2^W: {co,s} = a + b + ci exactly.
- Nibble carry chains across cycles only through carry_reg; no combinational path from inputs to outputs.
- cnt width is clog2(NIBBLES)+1. There is no wrap-around inside an operation.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro SER_ADD_OVF_EN.
- Defined:
  - Port ovf exists.
  - On the final nibble, ovf = carry-into-MSB XOR carry-out-of-MSB, i.e. two's-complement overflow of the W-bit add.
  - ovf is registered alongside s/co, held with them, and cleared by rst.
- Undefined: no ovf port or logic; the rest is unchanged.

Decomposition:
- Shared header/package: FSM state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the NIBBLE_W=4 constant.
- One sub-module: nibble_add4, a purely combinational 4-bit adder (a, b, ci → s, co).
  - Under SER_ADD_OVF_EN it also exposes the carry into bit 3.
  - Instantiated once.

Test Plan (NIBBLES=4):
- Reset: hold rst for 2 cycles with start=1 → busy=0, done=0, s=16'h0000, co=0; no RUN entry.
- Basic add: a=16'h1234, b=16'h4321, ci=0, one-cycle start → busy high for 4 cycles, done on the 5th cycle, s=16'h5555, co=0.
- Full carry ripple: a=16'hFFFF, b=16'h0000, ci=1 → s=16'h0000, co=1. Then a=16'hFFFF, b=16'hFFFF, ci=1 → s=16'hFFFF, co=1.
- Busy-ignore and back-to-back:
  - Start a=16'h0001, b=16'h0001.
  - Pulse start with a=16'h00FF, b=16'h0001 during RUN → result s=16'h0002.
  - Start asserted in the DONE cycle with a=16'h00FF, b=16'h0001 → next result s=16'h0100 five cycles later.
- Reset mid-operation: assert rst on RUN cycle 2 → no done, s=0, busy=0. Then a=16'hABCD, b=16'h1111 → s=16'hBCDE, co=0.
- With SER_ADD_OVF_EN:
  - a=16'h7FFF, b=16'h0001 → s=16'h8000, co=0, ovf=1.
  - a=16'hFFFF, b=16'h0001 → s=16'h0000, co=1, ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_serial_adder_pkg                                                  |
// | Shared constants, FSM state encoding and sizing helper for the serial    |
// | nibble adder.                                                            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One spare bit so the counter never wraps for any legal NIBBLES.
   function automatic int cnt_width(input int nibbles);
      return $clog2(nibbles) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_add4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_add4                                                              |
// | Combinational 4-bit ripple adder slice; with SER_ADD_OVF_EN it also      |
// | exports the carry into its top bit.                                      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module nibble_add4
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
`ifdef SER_ADD_OVF_EN
   ,
   output logic                c3
`endif
);

   logic [NIBBLE_W:0] w_c;

   assign w_c[0] = ci;

   genvar i;
   for (i = 0; i < NIBBLE_W; i++) begin : g_bit
      assign s[i]       = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign co = w_c[NIBBLE_W];

`ifdef SER_ADD_OVF_EN
   assign c3 = w_c[NIBBLE_W-1];
`endif

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_serial_adder                                                      |
// | Wide adder that reuses one 4-bit slice for NIBBLES cycles, carrying      |
// | between nibbles through a register. Optional macro SER_ADD_OVF_EN adds   |
// | the signed-overflow output ovf.                                          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                        ci,
   output logic                        busy,
   output logic                        done,
   output logic [NIBBLE_W*NIBBLES-1:0] s,
   output logic                        co
`ifdef SER_ADD_OVF_EN
   ,
   output logic                        ovf
`endif
);

   localparam int c_w  = NIBBLE_W * NIBBLES;
   localparam int c_cw = cnt_width(NIBBLES);
   localparam logic [c_cw-1:0] c_last_cnt = c_cw'(NIBBLES - 1);
   localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

   state_t            r_state;
   logic [c_w-1:0]    r_a;
   logic [c_w-1:0]    r_b;
   logic [c_w-1:0]    r_res;
   logic [c_cw-1:0]   r_cnt;
   logic              r_carry;

   logic [NIBBLE_W-1:0] w_sum;
   logic                w_nco;
   logic [c_w-1:0]      w_res_next;
`ifdef SER_ADD_OVF_EN
   logic                w_c3;
`endif

   // Operands shift right each RUN edge, so the active nibble is always at the bottom.
   nibble_add4 u_add4 (
      .a  (r_a[NIBBLE_W-1:0]),
      .b  (r_b[NIBBLE_W-1:0]),
      .ci (r_carry),
      .s  (w_sum),
      .co (w_nco)
`ifdef SER_ADD_OVF_EN
      ,
      .c3 (w_c3)
`endif
   );

   always_comb begin
      w_res_next = r_res;
      w_res_next[int'(r_cnt)*NIBBLE_W +: NIBBLE_W] = w_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s       <= '0;
         co      <= 1'b0;
`ifdef SER_ADD_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= ci;
                  r_cnt   <= '0;
                  r_res   <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> NIBBLE_W;
               r_b     <= r_b >> NIBBLE_W;
               r_res   <= w_res_next;
               r_carry <= w_nco;
               r_cnt   <= r_cnt + c_cnt_one;
               if (r_cnt == c_last_cnt) begin
                  s       <= w_res_next;
                  co      <= w_nco;
`ifdef SER_ADD_OVF_EN
                  ovf     <= w_c3 ^ w_nco;
`endif
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nibble_serial_adder                                                   |
// | Directed scoreboard bench for nibble_serial_adder with NIBBLES=4.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_nibble_serial_adder;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         co;
`ifdef SER_ADD_OVF_EN
   logic         ovf;
`endif

   exp_t sb[$];
   exp_t last_exp;
   int   n_checks = 0;
   int   n_fail   = 0;

   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .co    (co)
`ifdef SER_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mc);
      exp_t        m;
      logic [W:0]  sum;
      sum   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      m.s   = sum[W-1:0];
      m.co  = sum[W];
      m.ovf = (ma[W-1] == mb[W-1]) && (sum[W-1] != ma[W-1]);
      return m;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input string tag, input exp_t e);
      chk({tag, ".s"}, 32'(s), 32'(e.s));
      chk({tag, ".co"}, 32'(co), 32'(e.co));
`ifdef SER_ADD_OVF_EN
      chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
   endtask

   // Called at a negedge: drives a one-cycle start and records the expected result.
   task automatic pulse_start(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
      a     = ta;
      b     = tb_;
      ci    = tc;
      start = 1'b1;
      sb.push_back(model(ta, tb_, tc));
      step();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      ci    = 1'($urandom);
   endtask

   // Waits for done, expecting it after exp_lat more cycles with busy high throughout.
   task automatic await_done(input string tag, input int exp_lat);
      int   n  = 0;
      int   nb = 0;
      exp_t e;
      while (!done && n < 20) begin
         if (busy) nb++;
         step();
         n++;
      end
      chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
      chk({tag, ".busy_cycles"}, 32'(nb), 32'(exp_lat));
      chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e        = sb.pop_front();
         last_exp = e;
         chk_result(tag, e);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h4321;
      ci    = 1'b0;

      // Reset held with start asserted
      step();
      step();
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.s", 32'(s), 32'h0000);
      chk("rst.co", 32'(co), 32'd0);
`ifdef SER_ADD_OVF_EN
      chk("rst.ovf", 32'(ovf), 32'd0);
`endif
      rst   = 1'b0;
      start = 1'b0;
      step();
      chk("rst.no_run", 32'(busy), 32'd0);

      pulse_start(16'h1234, 16'h4321, 1'b0);
      await_done("basic", NIBBLES);
      step();
      chk("basic.done_pulse", 32'(done), 32'd0);
      chk_result("basic.held", last_exp);

      pulse_start(16'hFFFF, 16'h0000, 1'b1);
      await_done("ripple1", NIBBLES);
      step();
      pulse_start(16'hFFFF, 16'hFFFF, 1'b1);
      await_done("ripple2", NIBBLES);
      step();

      // Start pulsed mid-operation must be ignored
      pulse_start(16'h0001, 16'h0001, 1'b0);
      step();
      a     = 16'h00FF;
      b     = 16'h0001;
      start = 1'b1;
      step();
      start = 1'b0;
      await_done("busy_ignore", NIBBLES - 2);

      // Back-to-back start in the DONE cycle
      pulse_start(16'h00FF, 16'h0001, 1'b0);
      await_done("b2b", NIBBLES);
      step();
      chk("b2b.done_pulse", 32'(done), 32'd0);
      chk_result("b2b.held", last_exp);

      // Reset on the second RUN cycle aborts the operation
      pulse_start(16'h1234, 16'h1111, 1'b0);
      void'(sb.pop_back());
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.s", 32'(s), 32'h0000);
      chk("abort.co", 32'(co), 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < NIBBLES + 3; i++) begin
            if (done) seen++;
            step();
         end
         chk("abort.no_done", 32'(seen), 32'd0);
      end
      pulse_start(16'hABCD, 16'h1111, 1'b0);
      await_done("after_abort", NIBBLES);
      step();

      pulse_start(16'h7FFF, 16'h0001, 1'b0);
      await_done("ovf_pos", NIBBLES);
      step();
      pulse_start(16'hFFFF, 16'h0001, 1'b0);
      await_done("ovf_wrap", NIBBLES);
      step();
      pulse_start(16'h8000, 16'h8000, 1'b0);
      await_done("ovf_neg", NIBBLES);
      step();

      for (int k = 0; k < 6; k++) begin
         pulse_start(16'($urandom), 16'($urandom), 1'($urandom));
         await_done("rand", NIBBLES);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before the directed sequence completed");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
